// File: rtl/word_block_register.sv
// Collects NUM_WORDS serial words of DATA_WIDTH bits into one wide block.
// The finished block is handed on with a valid/ready handshake.
module word_block_register #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_WORDS  = 4,
    parameter bit MSW_FIRST  = 1'b1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             cl,
    input  logic [DATA_WIDTH-1:0]            din,
    input  logic                             din_valid,
    output logic                             din_ready,
    output logic [DATA_WIDTH*NUM_WORDS-1:0]  dout,
    output logic                             dout_valid,
    input  logic                             dout_ready,
    output logic [$clog2(NUM_WORDS+1)-1:0]   count
);

    localparam int CW = $clog2(NUM_WORDS + 1);

    logic [DATA_WIDTH-1:0] r_slot [NUM_WORDS];
    logic [CW-1:0]         r_count;
    logic                  r_valid;

    logic                  w_accept;
    logic                  w_consume;
    logic [CW-1:0]         w_wr_idx;
    logic [CW-1:0]         w_next_count;

    // Ready while empty-ish, or when the held block leaves this same cycle.
    assign din_ready = !r_valid || dout_ready;
    assign w_accept  = din_valid && din_ready;
    assign w_consume = r_valid && dout_ready;

    // An accept while full can only coincide with a consume, so it starts a new block.
    assign w_wr_idx     = r_valid ? '0 : r_count;
    assign w_next_count = w_wr_idx + CW'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
            r_valid <= 1'b0;
            // NOTE: the slots are reset too, because the block must read as zero after reset or clear.
            for (int i = 0; i < NUM_WORDS; i++) r_slot[i] <= '0;
        end else if (cl) begin
            r_count <= '0;
            r_valid <= 1'b0;
            for (int i = 0; i < NUM_WORDS; i++) r_slot[i] <= '0;
        end else if (w_accept) begin
            for (int i = 0; i < NUM_WORDS; i++) begin
                if (w_wr_idx == CW'(i)) r_slot[i] <= din;
            end
            r_count <= w_next_count;
            r_valid <= (w_next_count == CW'(NUM_WORDS));
        end else if (w_consume) begin
            // Slot contents stay as stale data; only the bookkeeping is cleared.
            r_count <= '0;
            r_valid <= 1'b0;
        end
    end

    for (genvar g = 0; g < NUM_WORDS; g++) begin : g_map
        if (MSW_FIRST) begin : g_msw
            assign dout[(NUM_WORDS-1-g)*DATA_WIDTH +: DATA_WIDTH] = r_slot[g];
        end else begin : g_lsw
            assign dout[g*DATA_WIDTH +: DATA_WIDTH] = r_slot[g];
        end
    end

    assign dout_valid = r_valid;
    assign count      = r_count;

endmodule

// File: tb/tb_word_block_register.sv
// Randomised and directed bench for word_block_register, covering both word orders.
// A slot-array reference model predicts the outputs of both DUT instances.
module tb_word_block_register;

    localparam int DW = 32;
    localparam int NW = 4;
    localparam int BW = DW * NW;
    localparam int CW = $clog2(NW + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          cl;
    logic [DW-1:0] din;
    logic          din_valid;
    logic          dout_ready;

    logic          ready_m, ready_l, valid_m, valid_l;
    logic [BW-1:0] dout_m, dout_l;
    logic [CW-1:0] count_m, count_l;

    always #5 clk = ~clk;

    word_block_register #(.DATA_WIDTH(DW), .NUM_WORDS(NW), .MSW_FIRST(1'b1)) u_dut_msw (
        .clk(clk), .rst(rst), .cl(cl), .din(din), .din_valid(din_valid), .din_ready(ready_m),
        .dout(dout_m), .dout_valid(valid_m), .dout_ready(dout_ready), .count(count_m)
    );

    word_block_register #(.DATA_WIDTH(DW), .NUM_WORDS(NW), .MSW_FIRST(1'b0)) u_dut_lsw (
        .clk(clk), .rst(rst), .cl(cl), .din(din), .din_valid(din_valid), .din_ready(ready_l),
        .dout(dout_l), .dout_valid(valid_l), .dout_ready(dout_ready), .count(count_l)
    );

    // Reference model: arrival-order slots, word count, and a block-complete flag.
    logic [DW-1:0] m_slot [NW];
    int            m_count;
    bit            m_full;

    int n_checks = 0;
    int n_fails  = 0;

    task automatic check(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [BW-1:0] exp_dout(input bit msw);
        logic [BW-1:0] v;
        int            pos;
        v = '0;
        for (int i = 0; i < NW; i++) begin
            pos = msw ? (NW - 1 - i) : i;
            v   = v | (BW'(m_slot[i]) << (pos * DW));
        end
        return v;
    endfunction

    task automatic model_reset();
        m_count = 0;
        m_full  = 1'b0;
        for (int i = 0; i < NW; i++) m_slot[i] = '0;
    endtask

    task automatic model_edge(input logic c, input logic dv, input logic [DW-1:0] d, input logic dr);
        bit rdy;
        rdy = !m_full || dr;
        if (c) begin
            model_reset();
        end else if (dv && rdy) begin
            if (m_full) begin
                m_slot[0] = d;
                m_count   = 1;
                m_full    = 1'b0;
            end else begin
                m_slot[m_count] = d;
                m_count++;
                m_full = (m_count == NW);
            end
        end else if (m_full && dr) begin
            m_count = 0;
            m_full  = 1'b0;
        end
    endtask

    task automatic check_outputs();
        check("count_msw", BW'(count_m), BW'(m_count));
        check("count_lsw", BW'(count_l), BW'(m_count));
        check("valid_msw", BW'(valid_m), BW'(m_full));
        check("valid_lsw", BW'(valid_l), BW'(m_full));
        check("dout_msw", dout_m, exp_dout(1'b1));
        check("dout_lsw", dout_l, exp_dout(1'b0));
    endtask

    // Drive one cycle of inputs from a falling edge, then check the registered result.
    task automatic step(input logic c, input logic dv, input logic [DW-1:0] d, input logic dr);
        cl = c; din_valid = dv; din = d; dout_ready = dr;
        #1;
        check("din_ready_msw", BW'(ready_m), BW'(!m_full || dr));
        check("din_ready_lsw", BW'(ready_l), BW'(!m_full || dr));
        @(posedge clk);
        model_edge(c, dv, d, dr);
        #1;
        check_outputs();
        @(negedge clk);
    endtask

    // Assert rst between clock edges and check its effect before any edge arrives.
    task automatic async_reset();
        cl = 1'b0; din_valid = 1'b0; dout_ready = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("rst_count", BW'(count_m), '0);
        check("rst_valid", BW'(valid_m), '0);
        check("rst_dout_msw", dout_m, '0);
        check("rst_dout_lsw", dout_l, '0);
        check("rst_din_ready", BW'(ready_m), BW'(1));
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [DW-1:0] words [NW];
        logic [BW-1:0] held;
        words[0] = 32'hA0; words[1] = 32'hB1; words[2] = 32'hC2; words[3] = 32'hD3;

        rst = 1'b1; cl = 1'b0; din = '0; din_valid = 1'b0; dout_ready = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check("por_count", BW'(count_m), '0);
        check("por_valid", BW'(valid_l), '0);
        check("por_dout", dout_m, '0);
        check("por_ready", BW'(ready_l), BW'(1));
        rst = 1'b0;

        // Reset in the middle of a fill.
        step(1'b0, 1'b1, 32'h11111111, 1'b0);
        step(1'b0, 1'b1, 32'h22222222, 1'b0);
        async_reset();

        // Basic fill, both word orders.
        for (int i = 0; i < NW; i++) step(1'b0, 1'b1, words[i], 1'b0);
        check("fill_dout_msw", dout_m, 128'h000000A0_000000B1_000000C2_000000D3);
        check("fill_dout_lsw", dout_l, 128'h000000D3_000000C2_000000B1_000000A0);
        check("fill_count", BW'(count_m), BW'(4));
        check("fill_valid", BW'(valid_m), BW'(1));
        check("fill_din_ready", BW'(ready_m), '0);

        // Backpressure: nothing may be taken while the block is held.
        held = dout_m;
        repeat (10) step(1'b0, 1'b1, 32'hFF, 1'b0);
        check("hold_dout", dout_m, held);
        check("hold_count", BW'(count_m), BW'(4));
        step(1'b0, 1'b0, 32'h0, 1'b1);
        check("drain_valid", BW'(valid_m), '0);
        check("drain_count", BW'(count_m), '0);
        check("drain_keeps_data", dout_m, held);

        // Back-to-back blocks: consume and first word of the next block in one cycle.
        for (int i = 0; i < NW; i++) step(1'b0, 1'b1, words[i], 1'b0);
        step(1'b0, 1'b1, 32'h55, 1'b1);
        check("b2b_count", BW'(count_m), BW'(1));
        check("b2b_valid", BW'(valid_m), '0);
        check("b2b_slot0", BW'(dout_m[BW-1 -: DW]), BW'(32'h55));
        for (int i = 1; i < NW; i++) begin
            check("b2b_not_yet_valid", BW'(valid_m), '0);
            step(1'b0, 1'b1, 32'h60 + DW'(i), 1'b0);
        end
        check("b2b_valid_after_4", BW'(valid_m), BW'(1));
        check("b2b_dout", dout_m, 128'h00000055_00000061_00000062_00000063);

        // Clear beats an accept, and also beats a consume.
        step(1'b0, 1'b0, 32'h0, 1'b1);
        for (int i = 0; i < NW - 1; i++) step(1'b0, 1'b1, words[i], 1'b0);
        step(1'b1, 1'b1, 32'h99, 1'b0);
        check("clr_count", BW'(count_m), '0);
        check("clr_dout", dout_m, '0);
        check("clr_valid", BW'(valid_m), '0);
        for (int i = 0; i < NW; i++) step(1'b0, 1'b1, words[i], 1'b0);
        step(1'b1, 1'b1, 32'h99, 1'b1);
        check("clr_consume_count", BW'(count_l), '0);
        check("clr_consume_dout", dout_l, '0);
        check("clr_consume_valid", BW'(valid_l), '0);

        // Randomised traffic against the model.
        for (int n = 0; n < 800; n++) begin
            if ($urandom_range(0, 59) == 0) begin
                async_reset();
            end else begin
                step($urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0,
                     $urandom, $urandom_range(0, 2) == 0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
